dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Memory-stage initiator that sits between the CPU pipeline and the `MemoryWithStack` data memory. It accepts one memory-class instruction at a time (LW, SW, PUSH, POP, CALL, RET), owns the architectural stack pointer, and drives the memory request bus with a req/ack handshake. It returns load and pop results to write-back and return targets to fetch. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, word-address width
- `STACK_TOP`, 32'h0000_00FF, SP reset value; the stack is empty when SP equals this
- `STACK_LIMIT`, 32'h0000_00C0, lowest legal SP; the stack is full when SP equals this

Ports. One clock; reset is synchronous and active-high.
- `clk` in 1: system clock, rising edge
- `reset` in 1: synchronous, active-high
- `in_valid` in 1: pipeline presents an instruction
- `in_ready` out 1: the block can accept an instruction
- `opcode` in 6: instruction opcode
- `rd` in 5: destination register for LW/POP
- `address` in 32: effective address for LW/SW
- `data_in` in 32: store or push data
- `pc` in 32: PC of the instruction, used by CALL
- `mem_read` out 1: memory read request
- `mem_write` out 1: memory write request
- `mem_addr` out 32: request address
- `mem_wdata` out 32: request write data
- `mem_rdata` in 32: read data, valid with `mem_ack`
- `mem_ack` in 1: memory completion strobe
- `wb_valid` out 1: one-cycle write-back strobe
- `wb_rd` out 5: write-back register
- `wb_data` out 32: write-back data
- `pc_valid` out 1: one-cycle RET target strobe
- `pc_target` out 32: return address
- `sp` out 32: current stack pointer
- `stall` out 1: equals `!in_ready`
- `fault` out 1: one-cycle strobe on stack overflow, stack underflow, or illegal opcode

## Operation
- Opcodes are LW=6'b001010, SW=6'b001011, CALL=6'b001101, RET=6'b001110, PUSH=6'b001111, POP=6'b010000. Any other opcode accepted with `in_valid` raises `fault` and produces no memory access.
- The stack grows downward and SP points at the top full word.
  - PUSH and CALL write to SP-1, then SP <= SP-1.
  - POP and RET read at SP, then SP <= SP+1.
  - SP arithmetic is 32-bit and wraps modulo 2^32, but the guards below prevent wrapping in legal use.
- CALL writes `pc`+1.
- RET returns the read data on `pc_target` with `pc_valid`.
- LW and POP return the read data on `wb_data` with `wb_rd` and `wb_valid`.
- Guards, checked at accept:
  - PUSH or CALL when SP==STACK_LIMIT: overflow.
  - POP or RET when SP==STACK_TOP: underflow.
  - On either, assert `fault`, issue no access, and leave SP unchanged.
- FSM:
  - IDLE: `in_ready`=1. On `in_valid`, latch the operands, compute the request, and go to REQ. On a guard or illegal opcode, go to FAULT.
  - REQ: assert `mem_read` or `mem_write` (never both). Hold `mem_addr` and `mem_wdata` stable. On `mem_ack`, capture `mem_rdata`, update SP, and go to RESP.
  - RESP: pulse `wb_valid` or `pc_valid` as applicable, then go to IDLE.
  - FAULT: pulse `fault`, then go to IDLE.
- `mem_ack` is ignored outside REQ.
- SP updates only on `mem_ack`, so `sp` shows the pre-op value throughout REQ.

## Timing
- Reset values: `in_ready`=1, `stall`=0, all strobes 0, `mem_read`/`mem_write`=0, `mem_addr`/`mem_wdata`/`wb_data`/`pc_target`=0, `wb_rd`=0, `sp`=STACK_TOP, FSM=IDLE.
- Request timing: accept at edge N. The request is visible from cycle N+1 until the edge where `mem_ack`=1 is sampled, and is deasserted on the following cycle.
- With a zero-wait memory (ack in the first REQ cycle), the response strobe comes 2 cycles after accept and the next accept follows 3 cycles after accept.
- Any memory latency ≥1 cycle is tolerated, with no timeout.
- The response strobe is exactly one cycle wide.
- `in_ready` falls the cycle after accept and rises in the cycle after RESP or FAULT; no back-to-back accepts.
- `reset` asserted in any state: on the next edge, drop the outstanding request, return to IDLE, restore SP, and suppress the strobes. A late `mem_ack` after reset is ignored.

## Structure
- Shared package `cpu_pkg`: opcode localparams, FSM state enum, `ADDR_W` default.
- Optional sub-module `stack_ptr_unit`: SP register, guard comparators, and next-SP adder/subtractor. All other logic stays in `dmem_access_ctrl`.

## Test plan
- SW, then LW: SW with address=4, data_in=32'h12345678, then LW with address=4, rd=3, and a 0-wait memory model -> a single `mem_write` cycle with `mem_addr`=4; LW gives `wb_valid` with `wb_rd`=3 and `wb_data`=32'h12345678.
- PUSH, then POP: PUSH 32'hAABBCCDD, then POP with rd=1 -> `mem_addr`=32'hFE on both; `sp` goes FF→FE→FF; `wb_data`=32'hAABBCCDD.
- CALL, then RET: CALL with pc=32'h40, then RET -> memory at FE holds 32'h41; `pc_valid` with `pc_target`=32'h41; `sp` returns to FF.
- Guards: POP at reset gives `fault` with no `mem_read`. 63 PUSHes bring `sp` to C0; a 64th PUSH gives `fault` and `sp` stays C0.
- Latency and reset: an LW with `mem_ack` delayed 5 cycles keeps the request stable for 5 cycles and `stall`=1 throughout. Assert `reset` mid-REQ -> next cycle `mem_read`=0, `sp`=FF, and a later ack produces no `wb_valid`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared opcode encodings and FSM state type for the memory-stage controller.
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;

  localparam logic [5:0] OP_LW   = 6'b001010;
  localparam logic [5:0] OP_SW   = 6'b001011;
  localparam logic [5:0] OP_CALL = 6'b001101;
  localparam logic [5:0] OP_RET  = 6'b001110;
  localparam logic [5:0] OP_PUSH = 6'b001111;
  localparam logic [5:0] OP_POP  = 6'b010000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/stack_ptr_unit.sv
// Architectural stack pointer with full/empty guards and pre-decremented address.
module stack_ptr_unit #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 'h0000_00FF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 'h0000_00C0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic [ADDR_W-1:0] sp_dec_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [ADDR_W-1:0] sp_q;
  logic [ADDR_W-1:0] sp_d;

  always_comb begin
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q - 1'b1;
    else if (pop_i) sp_d = sp_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) sp_q <= STACK_TOP;
    else       sp_q <= sp_d;
  end

  assign sp_o     = sp_q;
  assign sp_dec_o = sp_q - 1'b1;
  assign full_o   = (sp_q == STACK_LIMIT);
  assign empty_o  = (sp_q == STACK_TOP);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Memory-stage initiator: one LW/SW/PUSH/POP/CALL/RET at a time over a req/ack bus.
// Stalls the pipeline from accept until the response or fault strobe.
module dmem_access_ctrl
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 'h0000_00FF,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 'h0000_00C0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  input  logic [31:0]       pc,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              pc_valid,
  output logic [31:0]       pc_target,
  output logic [ADDR_W-1:0] sp,
  output logic              stall,
  output logic              fault
);

  state_t            state_q;
  logic [5:0]        op_q;
  logic [4:0]        rd_q;
  logic              in_ready_q, mem_read_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q, wb_data_q, pc_target_q;
  logic [4:0]        wb_rd_q;
  logic              wb_valid_q, pc_valid_q, fault_q;

  logic              ack_q_cycle, sp_push, sp_pop, sp_full, sp_empty;
  logic [ADDR_W-1:0] sp_cur, sp_dec;

  // SP moves only on the completing edge of a stack access.
  assign ack_q_cycle = (state_q == ST_REQ) && mem_ack;
  assign sp_push     = ack_q_cycle && (op_q == OP_PUSH || op_q == OP_CALL);
  assign sp_pop      = ack_q_cycle && (op_q == OP_POP  || op_q == OP_RET);

  stack_ptr_unit #(
    .ADDR_W      (ADDR_W),
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_sp (
    .clk      (clk),
    .reset    (reset),
    .push_i   (sp_push),
    .pop_i    (sp_pop),
    .sp_o     (sp_cur),
    .sp_dec_o (sp_dec),
    .full_o   (sp_full),
    .empty_o  (sp_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      rd_q        <= '0;
      in_ready_q  <= 1'b1;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_data_q   <= '0;
      wb_rd_q     <= '0;
      pc_target_q <= '0;
      wb_valid_q  <= 1'b0;
      pc_valid_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      pc_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            op_q       <= opcode;
            rd_q       <= rd;
            state_q    <= ST_REQ;
            case (opcode)
              OP_LW: begin
                mem_read_q <= 1'b1;
                mem_addr_q <= address;
              end
              OP_SW: begin
                mem_write_q <= 1'b1;
                mem_addr_q  <= address;
                mem_wdata_q <= data_in;
              end
              OP_PUSH, OP_CALL: begin
                if (sp_full) begin
                  state_q <= ST_FAULT;
                end else begin
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= sp_dec;
                  mem_wdata_q <= (opcode == OP_CALL) ? pc + 32'd1 : data_in;
                end
              end
              OP_POP, OP_RET: begin
                if (sp_empty) begin
                  state_q <= ST_FAULT;
                end else begin
                  mem_read_q <= 1'b1;
                  mem_addr_q <= sp_cur;
                end
              end
              default: state_q <= ST_FAULT;
            endcase
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (op_q == OP_LW || op_q == OP_POP) begin
              wb_data_q <= mem_rdata;
              wb_rd_q   <= rd_q;
            end
            if (op_q == OP_RET) pc_target_q <= mem_rdata;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          wb_valid_q <= (op_q == OP_LW || op_q == OP_POP);
          pc_valid_q <= (op_q == OP_RET);
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        ST_FAULT: begin
          fault_q    <= 1'b1;
          in_ready_q <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign stall     = !in_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign pc_valid  = pc_valid_q;
  assign pc_target = pc_target_q;
  assign sp        = sp_cur;
  assign fault     = fault_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Randomized bench for dmem_access_ctrl against a word-memory/stack reference model.
module tb_dmem_access_ctrl;

  localparam logic [5:0]  LW = 6'b001010, SW = 6'b001011, CALL = 6'b001101;
  localparam logic [5:0]  RET = 6'b001110, PUSH = 6'b001111, POP = 6'b010000;
  localparam logic [31:0] TOP = 32'hFF, LIMIT = 32'hC0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [4:0]  rd = '0;
  logic [31:0] address = '0, data_in = '0, pc = '0;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        wb_valid, pc_valid, stall, fault;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, pc_target, sp;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] sp_m;

  dmem_access_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .address(address), .data_in(data_in), .pc(pc),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .pc_valid(pc_valid), .pc_target(pc_target), .sp(sp),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  // Issue one instruction and follow it to completion, comparing every cycle.
  task automatic do_op(input logic [5:0] op, input logic [4:0] rdv, input logic [31:0] addr,
                       input logic [31:0] dat, input logic [31:0] pcv, input int lat);
    bit          legal, flt, is_wr, is_ld, is_ret;
    logic [31:0] ea, wd, rdat, sp_pre, sp_post;
    legal  = (op == LW || op == SW || op == CALL || op == RET || op == PUSH || op == POP);
    is_wr  = (op == SW || op == PUSH || op == CALL);
    is_ld  = (op == LW || op == POP);
    is_ret = (op == RET);
    flt    = !legal || ((op == PUSH || op == CALL) && sp_m == LIMIT)
                    || ((op == POP || op == RET) && sp_m == TOP);
    sp_pre = sp_m;
    ea = (op == LW || op == SW) ? addr : ((op == PUSH || op == CALL) ? sp_m - 1 : sp_m);
    wd = (op == CALL) ? pcv + 1 : dat;

    chk("ready_before", {31'b0, in_ready}, 32'h1);
    in_valid = 1'b1; opcode = op; rd = rdv; address = addr; data_in = dat; pc = pcv;
    tick();
    in_valid = 1'b0;

    if (flt) begin
      chk("flt_rd", {31'b0, mem_read}, 32'h0);
      chk("flt_wr", {31'b0, mem_write}, 32'h0);
      chk("flt_stall", {31'b0, stall}, 32'h1);
      tick();
      chk("flt_strobe", {31'b0, fault}, 32'h1);
      chk("flt_ready", {31'b0, in_ready}, 32'h1);
      chk("flt_sp", sp, sp_pre);
    end else begin
      for (int i = 0; i <= lat; i++) begin
        chk("req_rd", {31'b0, mem_read}, {31'b0, !is_wr});
        chk("req_wr", {31'b0, mem_write}, {31'b0, is_wr});
        chk("req_addr", mem_addr, ea);
        if (is_wr) chk("req_wdata", mem_wdata, wd);
        chk("req_stall", {31'b0, stall}, 32'h1);
        chk("req_sp", sp, sp_pre);
        if (i == lat) begin
          mem_ack = 1'b1;
          mem_rdata = is_wr ? $urandom : mem_rd(ea);
        end
        tick();
        mem_ack = 1'b0;
      end
      rdat = mem_rd(ea);
      if (is_wr) mem_m[ea] = wd;
      if (op == PUSH || op == CALL) sp_m = sp_m - 1;
      if (op == POP || op == RET)   sp_m = sp_m + 1;
      sp_post = sp_m;
      chk("resp_rd", {31'b0, mem_read | mem_write}, 32'h0);
      chk("resp_early", {31'b0, wb_valid | pc_valid}, 32'h0);
      chk("resp_stall", {31'b0, stall}, 32'h1);
      chk("resp_sp", sp, sp_post);
      tick();
      chk("wb_valid", {31'b0, wb_valid}, {31'b0, is_ld});
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, is_ret});
      if (is_ld) begin
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, rdv});
        chk("wb_data", wb_data, rdat);
      end
      if (is_ret) chk("pc_target", pc_target, rdat);
      chk("done_ready", {31'b0, in_ready}, 32'h1);
    end
    tick();
    chk("strobe_width", {29'b0, wb_valid, pc_valid, fault}, 32'h0);
    chk("sp_model", sp, sp_m);
  endtask

  initial begin
    logic [5:0] rop;
    sp_m = TOP;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_req", {30'b0, mem_read, mem_write}, 32'h0);
    chk("rst_strobes", {29'b0, wb_valid, pc_valid, fault}, 32'h0);
    chk("rst_sp", sp, TOP);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_pct", pc_target, 32'h0);
    chk("rst_wbrd", {27'b0, wb_rd}, 32'h0);

    // Directed scenarios.
    do_op(POP, 5'd1, 0, 0, 0, 0);
    do_op(SW, 5'd0, 32'd4, 32'h12345678, 0, 0);
    do_op(LW, 5'd3, 32'd4, 0, 0, 0);
    chk("lw_data", wb_data, 32'h12345678);
    do_op(PUSH, 5'd0, 0, 32'hAABBCCDD, 0, 0);
    chk("push_sp", sp, 32'hFE);
    do_op(POP, 5'd1, 0, 0, 0, 1);
    chk("pop_data", wb_data, 32'hAABBCCDD);
    do_op(CALL, 5'd0, 0, 0, 32'h40, 0);
    chk("call_mem", mem_rd(32'hFE), 32'h41);
    do_op(RET, 5'd0, 0, 0, 0, 2);
    chk("ret_target", pc_target, 32'h41);
    chk("ret_sp", sp, TOP);
    for (int i = 0; i < 63; i++) do_op(PUSH, 5'd0, 0, $urandom, 0, $urandom_range(0, 1));
    chk("full_sp", sp, LIMIT);
    do_op(PUSH, 5'd0, 0, 32'h1, 0, 0);
    chk("ovf_sp", sp, LIMIT);
    do_op(CALL, 5'd0, 0, 0, 32'h10, 0);
    do_op(LW, 5'd7, 32'd4, 0, 0, 5);
    do_op(6'b111111, 5'd0, 0, 0, 0, 0);

    // Randomized mix; a stray ack while idle must be ignored.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 6))
        0: rop = LW;
        1: rop = SW;
        2: rop = CALL;
        3: rop = RET;
        4: rop = PUSH;
        5: rop = POP;
        default: begin
          rop = 6'($urandom);
          if (rop == LW || rop == SW || rop == CALL || rop == RET || rop == PUSH || rop == POP)
            rop = 6'b000000;
        end
      endcase
      if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("idle_ack", {29'b0, wb_valid, pc_valid, mem_read}, 32'h0);
        chk("idle_ack_sp", sp, sp_m);
      end
      do_op(rop, 5'($urandom), 32'($urandom_range(0, 31)), $urandom, $urandom,
            $urandom_range(0, 4));
    end

    // Reset in the middle of an outstanding read.
    in_valid = 1'b1; opcode = LW; rd = 5'd9; address = 32'd5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("mid_req", {31'b0, mem_read}, 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sp_m = TOP;
    chk("rst_mid_rd", {31'b0, mem_read}, 32'h0);
    chk("rst_mid_sp", sp, TOP);
    chk("rst_mid_ready", {31'b0, in_ready}, 32'h1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("late_ack_wb", {31'b0, wb_valid}, 32'h0);
    tick();
    chk("late_ack_wb2", {30'b0, wb_valid, mem_read}, 32'h0);
    do_op(POP, 5'd2, 0, 0, 0, 0);
    do_op(SW, 5'd0, 32'd6, 32'hCAFEF00D, 0, 3);
    do_op(LW, 5'd4, 32'd6, 0, 0, 0);
    chk("final_lw", wb_data, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
